erode_detector: RTL and testbench
=================================

ERODE_DETECTOR -- requirements
Module: erode_detector

Interface
REQ-001 The module SHALL have parameter IMG_HDISP, default 10'd640, active pixels per line.
REQ-002 The module SHALL have parameter IMG_VDISP, default 10'd480, active lines per frame.
REQ-003 clk  input  1  video pixel clock; sole clock of the block.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 per_frame_vsync  input  1  frame valid, high for the whole frame.
REQ-006 per_frame_href  input  1  line valid, high during active pixels of a line.
REQ-007 per_frame_clken  input  1  pixel enable; a pixel is accepted when clken and href are both high.
REQ-008 per_img_Bit  input  1  binary pixel, 1 = white, 0 = black.
REQ-009 post_frame_vsync  output  1  per_frame_vsync delayed 3 clk.
REQ-010 post_frame_href  output  1  per_frame_href delayed 3 clk.
REQ-011 post_frame_clken  output  1  per_frame_clken delayed 3 clk.
REQ-012 post_img_Bit  output  1  eroded pixel; 0 whenever post_frame_href is low.

Function
REQ-013 Erosion SHALL be the AND of all nine 3x3 window bits; output 1 only if all nine are 1.
REQ-014 The block SHALL build the window itself with two 1-bit line buffers, each IMG_HDISP deep, addressed by col_cnt.
REQ-015 col_cnt (10 bit) SHALL clear when per_frame_href is low and increment by 1 per accepted pixel, saturating at 1023.
REQ-016 row_cnt (10 bit) SHALL clear when per_frame_vsync is low and increment by 1 on each href falling edge (href registered, then detect), saturating at 1023.
REQ-017 On an accepted pixel with col_cnt < IMG_HDISP: lb1[col_cnt] <= per_img_Bit, lb2[col_cnt] <= old lb1[col_cnt].
REQ-018 Window stage (W), on an accepted pixel only: columns shift left; new right column p13 = old lb2[col_cnt], p23 = old lb1[col_cnt], p33 = per_img_Bit.
REQ-019 Stage W SHALL also register a valid flag = (row_cnt >= 2) and (2 <= col_cnt < IMG_HDISP) for the accepted pixel; flag holds when no pixel is accepted.
REQ-020 Stage A (every clk, ungated) SHALL register the three row ANDs and the valid flag; stage B (every clk) SHALL register AND of the row results AND valid.
REQ-021 Total latency SHALL be 3 clk: the pixel accepted at cycle t drives post_img_Bit at t+3, with result centred on input (row_cnt-1, col_cnt-1).
REQ-022 vsync/href/clken SHALL pass through a 3-stage shift register, ungated, so post_* control aligns exactly with the data of REQ-021.
REQ-023 Pixels with col_cnt >= IMG_HDISP SHALL not write the line buffers and SHALL produce output 0.
REQ-024 Rows 0-1 and columns 0-1 of every frame SHALL output 0 (window not fully inside the frame).
REQ-025 Cycles with clken low inside href SHALL not change window, line buffers or col_cnt; the output bit is a don't-care there, but is forced 0 when post href is low.

Reset
REQ-026 rst high SHALL asynchronously clear col_cnt, row_cnt, window, valid flags, pipeline stages and control shift registers; all post_* outputs read 0.
REQ-027 Line buffer contents SHALL NOT need reset; stale data is masked by REQ-024 because row_cnt restarts at 0.
REQ-028 After rst deassertion mid-frame, output SHALL stay 0 until row_cnt reaches 2 (counting href falling edges since release).

Verification
REQ-029 IMG_HDISP=8, IMG_VDISP=6, all-ones frame, clken continuous -> post_img_Bit=1 exactly for rows 2..5 x cols 2..7 (24 pixels), 0 elsewhere; post_href = per_href delayed 3 clk.
REQ-030 Same frame with single 0 at input (3,4) -> outputs at (3..5, 4..6) are 0, remaining 15 valid positions are 1.
REQ-031 Scenario REQ-029 with clken high every other cycle -> bit sequence sampled on post_frame_clken identical to REQ-029.
REQ-032 All-zero frame -> post_img_Bit never 1; a following all-ones frame matches REQ-029 exactly (no stale-buffer leakage).
REQ-033 rst pulsed during row 3 -> all post_* 0 in the same cycle; next full all-ones frame matches REQ-029.
REQ-034 Lines of 10 accepted pixels with IMG_HDISP=8 -> cols 8..9 output 0; cols 0..7 results identical to REQ-029.

Source files
------------

// File: rtl/erode_detector.sv
// erode_detector: 3x3 binary erosion over a streamed frame, built from two line buffers, 3 clk latency.
module erode_detector #(
  parameter logic [9:0] IMG_HDISP = 10'd640,
  parameter logic [9:0] IMG_VDISP = 10'd480
) (
  input  logic clk,
  input  logic rst,
  input  logic per_frame_vsync,
  input  logic per_frame_href,
  input  logic per_frame_clken,
  input  logic per_img_Bit,
  output logic post_frame_vsync,
  output logic post_frame_href,
  output logic post_frame_clken,
  output logic post_img_Bit
);
  localparam int AW = $clog2(IMG_HDISP);
  logic [9:0] col_cnt, row_cnt;
  logic href_d;
  logic lb1 [0:IMG_HDISP-1];
  logic lb2 [0:IMG_HDISP-1];
  logic [2:0] win1, win2, win3;
  logic w_vld, a_vld, b_bit;
  logic [2:0] a_and;
  logic [2:0] vs_d, hr_d, ce_d;
  logic accept, in_range, valid, lb1_q, lb2_q;
  logic [AW-1:0] addr;
  assign accept   = per_frame_clken & per_frame_href;
  assign in_range = col_cnt < IMG_HDISP;
  assign addr     = col_cnt[AW-1:0];
  assign lb1_q    = in_range ? lb1[addr] : 1'b0;
  assign lb2_q    = in_range ? lb2[addr] : 1'b0;
  // window fully inside the frame only from the third row and third column on
  assign valid    = (row_cnt >= 10'd2) && (row_cnt < IMG_VDISP) && (col_cnt >= 10'd2) && in_range;
  always_ff @(posedge clk)
    if (accept && in_range) begin
      lb1[addr] <= per_img_Bit;
      lb2[addr] <= lb1[addr];
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
      href_d  <= 1'b0;
      win1    <= '0;
      win2    <= '0;
      win3    <= '0;
      w_vld   <= 1'b0;
      a_and   <= '0;
      a_vld   <= 1'b0;
      b_bit   <= 1'b0;
      vs_d    <= '0;
      hr_d    <= '0;
      ce_d    <= '0;
    end else begin
      col_cnt <= !per_frame_href ? '0 : (accept && col_cnt != '1) ? col_cnt + 10'd1 : col_cnt;
      href_d  <= per_frame_href;
      row_cnt <= !per_frame_vsync ? '0 : (href_d && !per_frame_href && row_cnt != '1) ? row_cnt + 10'd1 : row_cnt;
      if (accept) begin
        win1  <= {win1[1:0], lb2_q};
        win2  <= {win2[1:0], lb1_q};
        win3  <= {win3[1:0], per_img_Bit};
        w_vld <= valid;
      end
      a_and <= {&win1, &win2, &win3};
      a_vld <= w_vld;
      b_bit <= (&a_and) & a_vld;
      vs_d  <= {vs_d[1:0], per_frame_vsync};
      hr_d  <= {hr_d[1:0], per_frame_href};
      ce_d  <= {ce_d[1:0], per_frame_clken};
    end
  assign post_frame_vsync = vs_d[2];
  assign post_frame_href  = hr_d[2];
  assign post_frame_clken = ce_d[2];
  assign post_img_Bit     = hr_d[2] & b_bit;
endmodule

// File: tb/tb_erode_detector.sv
// tb_erode_detector: directed frames on an 8x6 image, checked against a bench-side erosion model.
module tb_erode_detector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic per_frame_vsync = 1'b0, per_frame_href = 1'b0, per_frame_clken = 1'b0, per_img_Bit = 1'b0;
  logic post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit;
  int checks = 0, failures = 0;
  int dly_err = 0, zero_viol = 0;
  logic img [6][10];
  logic exp_q [$];
  logic cap [$];
  logic [2:0] hv = '0, hh = '0, hc = '0;
  logic pre_href;
  logic [3:0] snap;

  erode_detector #(.IMG_HDISP(10'd8), .IMG_VDISP(10'd6)) dut (
    .clk(clk), .rst(rst),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_Bit(per_img_Bit),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_frame_clken(post_frame_clken), .post_img_Bit(post_img_Bit)
  );

  always #5 clk = ~clk;

  // capture outputs and track the 3-clk control delay away from the active edge
  always @(negedge clk)
    if (rst) begin
      hv = '0; hh = '0; hc = '0;
    end else begin
      if (post_frame_vsync !== hv[2] || post_frame_href !== hh[2] || post_frame_clken !== hc[2]) dly_err++;
      if (!post_frame_href && post_img_Bit !== 1'b0) zero_viol++;
      if (post_frame_href && post_frame_clken) cap.push_back(post_img_Bit);
      hv = {hv[1:0], per_frame_vsync};
      hh = {hh[1:0], per_frame_href};
      hc = {hc[1:0], per_frame_clken};
    end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic v);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 10; c++) img[r][c] = v;
  endtask

  function automatic logic expv(input int r, input int c);
    if (r < 2 || c < 2 || c >= 8) return 1'b0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (!img[r-2+i][c-2+j]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int mism();
    int n = 0;
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
      if (cap[i] !== exp_q[i]) n++;
    return n;
  endfunction

  function automatic int ones();
    int n = 0;
    foreach (cap[i]) if (cap[i] === 1'b1) n++;
    return n;
  endfunction

  task automatic drive_frame(input int width, input bit gap, input int rst_row);
    exp_q.delete();
    cap.delete();
    dly_err = 0;
    zero_viol = 0;
    per_frame_vsync = 1'b1;
    repeat (4) cyc();
    for (int r = 0; r < 6; r++) begin
      per_frame_href = 1'b1;
      for (int c = 0; c < width; c++) begin
        if (gap) begin
          per_frame_clken = 1'b0;
          per_img_Bit = 1'b0;
          cyc();
        end
        per_frame_clken = 1'b1;
        per_img_Bit = img[r][c];
        exp_q.push_back(expv(r, c));
        if (r == rst_row && c == 4) begin
          pre_href = post_frame_href;
          rst = 1'b1;
          #1 snap = {post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit};
        end
        cyc();
        rst = 1'b0;
      end
      per_frame_href = 1'b0;
      per_frame_clken = 1'b0;
      per_img_Bit = 1'b0;
      repeat (4) cyc();
    end
    per_frame_vsync = 1'b0;
    repeat (6) cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    per_frame_vsync = 1'b1; per_frame_href = 1'b1; per_frame_clken = 1'b1; per_img_Bit = 1'b1;
    repeat (4) cyc();
    checks++; if (post_frame_vsync !== 1'b0) begin failures++; $display("FAIL reset_vsync got=%b want=0", post_frame_vsync); end
    checks++; if (post_frame_href !== 1'b0) begin failures++; $display("FAIL reset_href got=%b want=0", post_frame_href); end
    checks++; if (post_frame_clken !== 1'b0) begin failures++; $display("FAIL reset_clken got=%b want=0", post_frame_clken); end
    checks++; if (post_img_Bit !== 1'b0) begin failures++; $display("FAIL reset_bit got=%b want=0", post_img_Bit); end
    per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_frame_clken = 1'b0; per_img_Bit = 1'b0;
    cyc();
    rst = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic test_all_ones();
    fill(1'b1);
    drive_frame(8, 1'b0, -1);
    checks++; if (cap.size() !== 48) begin failures++; $display("FAIL ones_count got=%0d want=48", cap.size()); end
    checks++; if (mism() !== 0) begin failures++; $display("FAIL ones_pixels mismatches=%0d want=0", mism()); end
    checks++; if (ones() !== 24) begin failures++; $display("FAIL ones_total got=%0d want=24", ones()); end
    checks++; if (dly_err !== 0) begin failures++; $display("FAIL ones_ctrl_delay errors=%0d want=0", dly_err); end
    checks++; if (zero_viol !== 0) begin failures++; $display("FAIL ones_href_low_bit errors=%0d want=0", zero_viol); end
  endtask

  task automatic test_single_zero();
    fill(1'b1);
    img[3][4] = 1'b0;
    drive_frame(8, 1'b0, -1);
    checks++; if (mism() !== 0) begin failures++; $display("FAIL zero_pixels mismatches=%0d want=0", mism()); end
    checks++; if (ones() !== 15) begin failures++; $display("FAIL zero_total got=%0d want=15", ones()); end
    checks++; if (cap.size() > 37 && cap[36] !== 1'b0) begin failures++; $display("FAIL zero_at_4_4 got=%b want=0", cap[36]); end
  endtask

  task automatic test_clken_gap();
    fill(1'b1);
    drive_frame(8, 1'b1, -1);
    checks++; if (cap.size() !== 48) begin failures++; $display("FAIL gap_count got=%0d want=48", cap.size()); end
    checks++; if (mism() !== 0) begin failures++; $display("FAIL gap_pixels mismatches=%0d want=0", mism()); end
    checks++; if (ones() !== 24) begin failures++; $display("FAIL gap_total got=%0d want=24", ones()); end
    checks++; if (dly_err !== 0) begin failures++; $display("FAIL gap_ctrl_delay errors=%0d want=0", dly_err); end
  endtask

  task automatic test_zero_then_ones();
    fill(1'b0);
    drive_frame(8, 1'b0, -1);
    checks++; if (ones() !== 0) begin failures++; $display("FAIL blank_total got=%0d want=0", ones()); end
    fill(1'b1);
    drive_frame(8, 1'b0, -1);
    checks++; if (mism() !== 0) begin failures++; $display("FAIL after_blank_pixels mismatches=%0d want=0", mism()); end
    checks++; if (ones() !== 24) begin failures++; $display("FAIL after_blank_total got=%0d want=24", ones()); end
  endtask

  task automatic test_reset_mid_frame();
    fill(1'b1);
    drive_frame(8, 1'b0, 3);
    checks++; if (pre_href !== 1'b1) begin failures++; $display("FAIL midrst_pre_href got=%b want=1", pre_href); end
    checks++; if (snap !== 4'b0000) begin failures++; $display("FAIL midrst_outputs got=%b want=0000", snap); end
    drive_frame(8, 1'b0, -1);
    checks++; if (mism() !== 0) begin failures++; $display("FAIL midrst_next_pixels mismatches=%0d want=0", mism()); end
    checks++; if (ones() !== 24) begin failures++; $display("FAIL midrst_next_total got=%0d want=24", ones()); end
  endtask

  task automatic test_long_lines();
    fill(1'b1);
    drive_frame(10, 1'b0, -1);
    checks++; if (cap.size() !== 60) begin failures++; $display("FAIL long_count got=%0d want=60", cap.size()); end
    checks++; if (mism() !== 0) begin failures++; $display("FAIL long_pixels mismatches=%0d want=0", mism()); end
    checks++; if (ones() !== 24) begin failures++; $display("FAIL long_total got=%0d want=24", ones()); end
    checks++; if (cap.size() == 60 && cap[59] !== 1'b0) begin failures++; $display("FAIL long_col9 got=%b want=0", cap[59]); end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_single_zero();
    test_clken_gap();
    test_zero_then_ones();
    test_reset_mid_frame();
    test_long_lines();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
